// File: rtl/regbank_bus_master_if.sv
// Command/response handshake between a command issuer and regbank_bus_master.
// The issuer uses the master modport and the bus master uses the slave modport.
interface regbank_bus_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_src;
  logic [3:0]  cmd_dst;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/regbank_bus_master.sv
// Sequences READ/WRITE/MOVE commands onto a strobed register-bank bus with a shared tristate DATA bus.
// Define REGBANK_BUS_MASTER_VERIFY_EN to add a readback-and-compare phase after every write.
module regbank_bus_master #(
  parameter int RD_WAIT = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  regbank_bus_master_if.slave  cmdIf,
  output logic                 o_rd,
  output logic                 o_wr,
  output logic [3:0]           o_sel,
  output logic                 o_driveEn,
  inout  wire  [15:0]          io_data
);

  typedef enum logic [2:0] {
    IDLE, RD_ASSERT, WR_SETUP, WR_STROBE, WR_HOLD, VFY_ASSERT, RESP
  } state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_MOVE  = 2'b10;
  localparam logic [2:0] WAIT_LAST = 3'(RD_WAIT);

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [1:0]  r_op;
  logic [3:0]  r_dst;
  logic [15:0] r_wdata;
  logic        r_rd;
  logic        r_wr;
  logic [3:0]  r_sel;
  logic        r_driveEn;
  logic        r_cmdReady;
  logic        r_rspValid;
  logic [15:0] r_rspData;
  logic        r_rspErr;

  assign o_rd      = r_rd;
  assign o_wr      = r_wr;
  assign o_sel     = r_sel;
  assign o_driveEn = r_driveEn;
  assign io_data   = r_driveEn ? r_wdata : 16'bz;

  assign cmdIf.cmd_ready = r_cmdReady;
  assign cmdIf.rsp_valid = r_rspValid;
  assign cmdIf.rsp_data  = r_rspData;
  assign cmdIf.rsp_err   = r_rspErr;

`ifdef REGBANK_BUS_MASTER_VERIFY_EN
  // Narrow registers return their byte in the low lane; SEL 4-7 hold the written high byte.
  logic w_vfyOk;
  always_comb begin
    w_vfyOk = 1'b0;
    case (r_sel[3:2])
      2'b00:   w_vfyOk = (r_wdata[7:0]  == io_data[7:0]);
      2'b01:   w_vfyOk = (r_wdata[15:8] == io_data[7:0]);
      default: w_vfyOk = (r_wdata == io_data);
    endcase
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_cnt      <= 3'd0;
      r_op       <= OP_READ;
      r_dst      <= 4'd0;
      r_wdata    <= 16'd0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_sel      <= 4'd0;
      r_driveEn  <= 1'b0;
      r_cmdReady <= 1'b0;
      r_rspValid <= 1'b0;
      r_rspData  <= 16'd0;
      r_rspErr   <= 1'b0;
    end else begin
      r_rspValid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!r_cmdReady) begin
            r_cmdReady <= 1'b1;
          end else if (cmdIf.cmd_valid) begin
            r_cmdReady <= 1'b0;
            r_op       <= cmdIf.cmd_op;
            r_dst      <= cmdIf.cmd_dst;
            r_wdata    <= cmdIf.cmd_wdata;
            r_cnt      <= 3'd0;
            case (cmdIf.cmd_op)
              OP_READ, OP_MOVE: begin
                r_rd    <= 1'b1;
                r_sel   <= cmdIf.cmd_src;
                r_state <= RD_ASSERT;
              end
              OP_WRITE: begin
                r_sel     <= cmdIf.cmd_dst;
                r_driveEn <= 1'b1;
                r_state   <= WR_SETUP;
              end
              default: begin
                r_rspValid <= 1'b1;
                r_rspErr   <= 1'b1;
                r_state    <= RESP;
              end
            endcase
          end
        end
        RD_ASSERT: begin
          if (r_cnt == WAIT_LAST) begin
            r_rd <= 1'b0;
            if (r_op == OP_MOVE) begin
              // The captured word is driven back out unchanged as the write data.
              r_wdata   <= io_data;
              r_sel     <= r_dst;
              r_driveEn <= 1'b1;
              r_state   <= WR_SETUP;
            end else begin
              r_rspData  <= io_data;
              r_rspErr   <= 1'b0;
              r_rspValid <= 1'b1;
              r_state    <= RESP;
            end
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        WR_SETUP: begin
          r_wr    <= 1'b1;
          r_state <= WR_STROBE;
        end
        WR_STROBE: begin
          r_wr    <= 1'b0;
          r_state <= WR_HOLD;
        end
        WR_HOLD: begin
          r_driveEn <= 1'b0;
`ifdef REGBANK_BUS_MASTER_VERIFY_EN
          r_rd    <= 1'b1;
          r_cnt   <= 3'd0;
          r_state <= VFY_ASSERT;
`else
          r_rspData  <= r_wdata;
          r_rspErr   <= 1'b0;
          r_rspValid <= 1'b1;
          r_state    <= RESP;
`endif
        end
`ifdef REGBANK_BUS_MASTER_VERIFY_EN
        VFY_ASSERT: begin
          if (r_cnt == WAIT_LAST) begin
            r_rd       <= 1'b0;
            r_rspData  <= io_data;
            r_rspErr   <= !w_vfyOk;
            r_rspValid <= 1'b1;
            r_state    <= RESP;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
`endif
        RESP: begin
          r_cmdReady <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_bus_master.sv
// Directed bench for regbank_bus_master: a vector table of commands with hand-computed
// latencies, strobe masks and responses, plus reset-abort and back-to-back sequences.
module tb_regbank_bus_master;

  localparam int RW = 1;

  logic        clk;
  logic        rst;
  logic        o_rd;
  logic        o_wr;
  logic [3:0]  o_sel;
  logic        o_driveEn;
  wire  [15:0] busData;

  regbank_bus_master_if cmdIf ();

  regbank_bus_master #(.RD_WAIT(RW)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .cmdIf     (cmdIf),
    .o_rd      (o_rd),
    .o_wr      (o_wr),
    .o_sel     (o_sel),
    .o_driveEn (o_driveEn),
    .io_data   (busData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register bank model: answers reads combinationally, captures writes on the strobe edge.
  logic [15:0] bankMem [16];
  logic        bankInit;
  logic        forceRb;
  logic [15:0] forceVal;

  assign busData = o_rd ? (forceRb ? forceVal : bankMem[o_sel]) : 16'bz;

  always @(posedge clk) begin
    if (bankInit) begin
      for (int i = 0; i < 16; i++) bankMem[i] <= 16'h1000 + 16'(i);
    end else if (o_wr) begin
      bankMem[o_sel] <= busData;
    end
  end

  // Bus rule watcher: read and write strobes exclusive, never drive while reading.
  int violations = 0;
  always @(negedge clk) begin
    if ((o_rd && o_wr) || (o_driveEn && o_rd)) violations++;
  end

  int vecCount  = 0;
  int missCount = 0;

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  src;
    logic [3:0]  dst;
    logic [15:0] wdata;
    logic        forceRb;
    logic [15:0] forceVal;
    int          expCycle;
    logic [15:0] expData;
    logic        expErr;
    logic [31:0] expWr;
    logic [31:0] expRd;
    logic [31:0] expDrv;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t makeVec(logic [1:0] op, logic [3:0] src, logic [3:0] dst,
                                   logic [15:0] wdata, logic fRb, logic [15:0] fVal,
                                   int cyc, logic [15:0] data, logic err,
                                   logic [31:0] wrM, logic [31:0] rdM, logic [31:0] drvM);
    vec_t v;
    v.op = op; v.src = src; v.dst = dst; v.wdata = wdata;
    v.forceRb = fRb; v.forceVal = fVal;
    v.expCycle = cyc; v.expData = data; v.expErr = err;
    v.expWr = wrM; v.expRd = rdM; v.expDrv = drvM;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one command, then record per-cycle strobe masks until the response pulse.
  task automatic applyStimulus(input vec_t v, input string tag);
    int n;
    int rspN;
    logic [31:0] wrM, rdM, drvM;
    logic [15:0] d;
    logic e;
    @(negedge clk);
    forceRb  = v.forceRb;
    forceVal = v.forceVal;
    cmdIf.cmd_op    = v.op;
    cmdIf.cmd_src   = v.src;
    cmdIf.cmd_dst   = v.dst;
    cmdIf.cmd_wdata = v.wdata;
    cmdIf.cmd_valid = 1'b1;
    n = 0;
    while (!cmdIf.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmdIf.cmd_ready) begin
      cmdIf.cmd_valid = 1'b0;
      checkOutput({tag, ".accept"}, 32'(cmdIf.cmd_ready), 32'd1);
      return;
    end
    @(posedge clk);
    #1;
    cmdIf.cmd_valid = 1'b0;
    cmdIf.cmd_src   = ~v.src;
    cmdIf.cmd_dst   = ~v.dst;
    cmdIf.cmd_wdata = ~v.wdata;
    wrM = 0; rdM = 0; drvM = 0; rspN = 0; d = 16'd0; e = 1'b0;
    for (int c = 1; c <= 30 && rspN == 0; c++) begin
      @(negedge clk);
      if (o_wr)      wrM[c]  = 1'b1;
      if (o_rd)      rdM[c]  = 1'b1;
      if (o_driveEn) drvM[c] = 1'b1;
      if (cmdIf.rsp_valid) begin
        rspN = c;
        d    = cmdIf.rsp_data;
        e    = cmdIf.rsp_err;
      end
    end
    forceRb = 1'b0;
    checkOutput({tag, ".rspCycle"}, 32'(rspN), 32'(v.expCycle));
    checkOutput({tag, ".rspData"},  32'(d),    32'(v.expData));
    checkOutput({tag, ".rspErr"},   32'(e),    32'(v.expErr));
    checkOutput({tag, ".wrMask"},   wrM,       v.expWr);
    checkOutput({tag, ".rdMask"},   rdM,       v.expRd);
    checkOutput({tag, ".drvMask"},  drvM,      v.expDrv);
  endtask

  initial begin
    int pulses;
    int acc;
    int nr;
    int t [3];
    logic [15:0] lastData;
    bit dropNext;

    rst = 1'b1;
    bankInit = 1'b1;
    forceRb = 1'b0;
    forceVal = 16'd0;
    cmdIf.cmd_valid = 1'b0;
    cmdIf.cmd_op    = 2'b00;
    cmdIf.cmd_src   = 4'd0;
    cmdIf.cmd_dst   = 4'd0;
    cmdIf.cmd_wdata = 16'd0;

    // Reset state, then ready one edge after reset is released.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.rd",       32'(o_rd), 32'd0);
    checkOutput("reset.wr",       32'(o_wr), 32'd0);
    checkOutput("reset.sel",      32'(o_sel), 32'd0);
    checkOutput("reset.driveEn",  32'(o_driveEn), 32'd0);
    checkOutput("reset.rspValid", 32'(cmdIf.rsp_valid), 32'd0);
    checkOutput("reset.rspErr",   32'(cmdIf.rsp_err), 32'd0);
    checkOutput("reset.rspData",  32'(cmdIf.rsp_data), 32'd0);
    checkOutput("reset.cmdReady", 32'(cmdIf.cmd_ready), 32'd0);
    rst = 1'b0;
    bankInit = 1'b0;
    @(negedge clk);
    checkOutput("reset.readyRise", 32'(cmdIf.cmd_ready), 32'd1);

    // Columns: op src dst wdata force forceVal | cycle data err wrMask rdMask drvMask
`ifdef REGBANK_BUS_MASTER_VERIFY_EN
    vecs.push_back(makeVec(2'b01, 4'd0,  4'd9,  16'hA5C3, 1'b0, 16'h0, 6, 16'hA5C3, 1'b0, 32'h04, 32'h30, 32'h0E));
    vecs.push_back(makeVec(2'b00, 4'd9,  4'd0,  16'h0000, 1'b0, 16'h0, 3, 16'hA5C3, 1'b0, 32'h00, 32'h06, 32'h00));
    vecs.push_back(makeVec(2'b01, 4'd0,  4'd2,  16'h12FF, 1'b0, 16'h0, 6, 16'h12FF, 1'b0, 32'h04, 32'h30, 32'h0E));
    vecs.push_back(makeVec(2'b10, 4'd2,  4'd12, 16'h0000, 1'b0, 16'h0, 8, 16'h12FF, 1'b0, 32'h10, 32'hC6, 32'h38));
    vecs.push_back(makeVec(2'b00, 4'd12, 4'd0,  16'h0000, 1'b0, 16'h0, 3, 16'h12FF, 1'b0, 32'h00, 32'h06, 32'h00));
    vecs.push_back(makeVec(2'b11, 4'd3,  4'd3,  16'hDEAD, 1'b0, 16'h0, 1, 16'h12FF, 1'b1, 32'h00, 32'h00, 32'h00));
    vecs.push_back(makeVec(2'b01, 4'd0,  4'd5,  16'h3412, 1'b0, 16'h0, 6, 16'h3412, 1'b1, 32'h04, 32'h30, 32'h0E));
    vecs.push_back(makeVec(2'b00, 4'd5,  4'd0,  16'h0000, 1'b0, 16'h0, 3, 16'h3412, 1'b0, 32'h00, 32'h06, 32'h00));
    vecs.push_back(makeVec(2'b01, 4'd0,  4'd6,  16'h7777, 1'b0, 16'h0, 6, 16'h7777, 1'b0, 32'h04, 32'h30, 32'h0E));
    vecs.push_back(makeVec(2'b00, 4'd7,  4'd0,  16'h0000, 1'b0, 16'h0, 3, 16'h1007, 1'b0, 32'h00, 32'h06, 32'h00));
    vecs.push_back(makeVec(2'b10, 4'd7,  4'd0,  16'h0000, 1'b0, 16'h0, 8, 16'h1007, 1'b0, 32'h10, 32'hC6, 32'h38));
    vecs.push_back(makeVec(2'b00, 4'd0,  4'd0,  16'h0000, 1'b0, 16'h0, 3, 16'h1007, 1'b0, 32'h00, 32'h06, 32'h00));
    vecs.push_back(makeVec(2'b01, 4'd0,  4'd10, 16'h5555, 1'b1, 16'h5554, 6, 16'h5554, 1'b1, 32'h04, 32'h30, 32'h0E));
`else
    vecs.push_back(makeVec(2'b01, 4'd0,  4'd9,  16'hA5C3, 1'b0, 16'h0, 4, 16'hA5C3, 1'b0, 32'h04, 32'h00, 32'h0E));
    vecs.push_back(makeVec(2'b00, 4'd9,  4'd0,  16'h0000, 1'b0, 16'h0, 3, 16'hA5C3, 1'b0, 32'h00, 32'h06, 32'h00));
    vecs.push_back(makeVec(2'b01, 4'd0,  4'd2,  16'h12FF, 1'b0, 16'h0, 4, 16'h12FF, 1'b0, 32'h04, 32'h00, 32'h0E));
    vecs.push_back(makeVec(2'b10, 4'd2,  4'd12, 16'h0000, 1'b0, 16'h0, 6, 16'h12FF, 1'b0, 32'h10, 32'h06, 32'h38));
    vecs.push_back(makeVec(2'b00, 4'd12, 4'd0,  16'h0000, 1'b0, 16'h0, 3, 16'h12FF, 1'b0, 32'h00, 32'h06, 32'h00));
    vecs.push_back(makeVec(2'b11, 4'd3,  4'd3,  16'hDEAD, 1'b0, 16'h0, 1, 16'h12FF, 1'b1, 32'h00, 32'h00, 32'h00));
    vecs.push_back(makeVec(2'b01, 4'd0,  4'd5,  16'h3412, 1'b0, 16'h0, 4, 16'h3412, 1'b0, 32'h04, 32'h00, 32'h0E));
    vecs.push_back(makeVec(2'b00, 4'd5,  4'd0,  16'h0000, 1'b0, 16'h0, 3, 16'h3412, 1'b0, 32'h00, 32'h06, 32'h00));
    vecs.push_back(makeVec(2'b01, 4'd0,  4'd6,  16'h7777, 1'b0, 16'h0, 4, 16'h7777, 1'b0, 32'h04, 32'h00, 32'h0E));
    vecs.push_back(makeVec(2'b00, 4'd7,  4'd0,  16'h0000, 1'b0, 16'h0, 3, 16'h1007, 1'b0, 32'h00, 32'h06, 32'h00));
    vecs.push_back(makeVec(2'b10, 4'd7,  4'd0,  16'h0000, 1'b0, 16'h0, 6, 16'h1007, 1'b0, 32'h10, 32'h06, 32'h38));
    vecs.push_back(makeVec(2'b00, 4'd0,  4'd0,  16'h0000, 1'b0, 16'h0, 3, 16'h1007, 1'b0, 32'h00, 32'h06, 32'h00));
    vecs.push_back(makeVec(2'b01, 4'd0,  4'd10, 16'h5555, 1'b0, 16'h0, 4, 16'h5555, 1'b0, 32'h04, 32'h00, 32'h0E));
`endif

    foreach (vecs[i]) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Reset during the first cycle of a WRITE to reg 9: the strobe never fires.
    @(negedge clk);
    cmdIf.cmd_op    = 2'b01;
    cmdIf.cmd_dst   = 4'd9;
    cmdIf.cmd_wdata = 16'h1111;
    cmdIf.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmdIf.cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("abort.driveC1", 32'(o_driveEn), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort.wr",       32'(o_wr), 32'd0);
    checkOutput("abort.driveEn",  32'(o_driveEn), 32'd0);
    checkOutput("abort.rd",       32'(o_rd), 32'd0);
    checkOutput("abort.rspValid", 32'(cmdIf.rsp_valid), 32'd0);
    rst = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (cmdIf.rsp_valid) pulses++;
    end
    checkOutput("abort.noRsp", 32'(pulses), 32'd0);
    applyStimulus(makeVec(2'b00, 4'd9, 4'd0, 16'h0, 1'b0, 16'h0, 3, 16'hA5C3, 1'b0,
                          32'h00, 32'h06, 32'h00), "abort.readBack");

    // Three READs with cmd_valid held high: one response every 4 cycles.
    acc = 0; nr = 0; dropNext = 1'b0; lastData = 16'd0;
    t[0] = 0; t[1] = 0; t[2] = 0;
    @(negedge clk);
    cmdIf.cmd_op    = 2'b00;
    cmdIf.cmd_src   = 4'd9;
    cmdIf.cmd_valid = 1'b1;
    for (int i = 0; i < 60 && nr < 3; i++) begin
      if (i > 0) @(negedge clk);
      if (dropNext) cmdIf.cmd_valid = 1'b0;
      if (cmdIf.rsp_valid) begin
        t[nr] = i;
        nr++;
        lastData = cmdIf.rsp_data;
      end
      if (cmdIf.cmd_valid && cmdIf.cmd_ready) begin
        acc++;
        if (acc == 3) dropNext = 1'b1;
      end
    end
    cmdIf.cmd_valid = 1'b0;
    checkOutput("b2b.rspCount", 32'(nr), 32'd3);
    checkOutput("b2b.gap1",     32'(t[1] - t[0]), 32'd4);
    checkOutput("b2b.gap2",     32'(t[2] - t[1]), 32'd4);
    checkOutput("b2b.data",     32'(lastData), 32'hA5C3);

    checkOutput("busRule.violations", 32'(violations), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
